// File: rtl/commu_seq.sv
// Phase sequencer for the commu_top path: fires NUM_PH phases in order and waits for each done,
// with a per-phase wait timeout and a bounded whole-sequence retry.
//
// state | meaning
// IDLE  | waiting for slot_rdy / cmd_re, retry_cnt holds last value
// BUF   | parked while pk_frm is high
// FIRE  | one-cycle fire pulse for phase ph_cur
// WAIT  | waiting for done[ph_cur] or timeout
// DONE  | one-cycle seq_ok pulse
// ERR   | one-cycle err_to pulse
module commu_seq #(
    parameter int NUM_PH    = 3,
    parameter int TO_W      = 16,
    parameter int TIMEOUT   = 1000,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_W   = 8,
    localparam int PH_W = (NUM_PH > 1) ? $clog2(NUM_PH) : 1,
    localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    output logic [NUM_PH-1:0]  fire,
    input  logic [NUM_PH-1:0]  done,
    input  logic               pk_frm,
    input  logic               slot_rdy,
    input  logic [RETRY_W-1:0] cmd_retry,
    output logic               busy,
    output logic [PH_W-1:0]    ph_cur,
    output logic [RC_W-1:0]    retry_cnt,
    output logic               seq_ok,
    output logic               err_to
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUF,
        S_FIRE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    // With the timeout disabled the counter just saturates at all-ones.
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '1 : TO_W'(TIMEOUT - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(NUM_PH - 1);
    localparam logic [RC_W-1:0] RC_MAX  = RC_W'(MAX_RETRY);

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic [PH_W-1:0] ph_nxt;
    logic            cmd_re;
    logic            cmd_unused;

    assign cmd_re     = cmd_retry[0] & cmd_retry[1];
    assign cmd_unused = ^cmd_retry;
    assign ph_nxt     = ph_cur + 1'b1;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            fire      <= '0;
            busy      <= 1'b0;
            seq_ok    <= 1'b0;
            err_to    <= 1'b0;
            ph_cur    <= '0;
            retry_cnt <= '0;
            to_cnt    <= '0;
        end else begin
            fire   <= '0;
            seq_ok <= 1'b0;
            err_to <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pk_frm) begin
                        state <= S_BUF;
                    end else if (slot_rdy || cmd_re) begin
                        state     <= S_FIRE;
                        ph_cur    <= '0;
                        retry_cnt <= '0;
                        fire      <= NUM_PH'(1);
                        busy      <= 1'b1;
                    end
                end
                S_BUF: begin
                    if (!pk_frm) state <= S_IDLE;
                end
                S_FIRE: begin
                    to_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    // done wins over a timeout landing in the same cycle
                    if (done[ph_cur]) begin
                        if (ph_cur == PH_LAST) begin
                            state  <= S_DONE;
                            seq_ok <= 1'b1;
                        end else begin
                            state  <= S_FIRE;
                            ph_cur <= ph_nxt;
                            fire   <= NUM_PH'(1) << ph_nxt;
                        end
                    end else if (TO_EN && to_cnt == TO_LAST) begin
                        if (retry_cnt < RC_MAX) begin
                            state     <= S_FIRE;
                            retry_cnt <= retry_cnt + 1'b1;
                            ph_cur    <= '0;
                            fire      <= NUM_PH'(1);
                        end else begin
                            state  <= S_ERR;
                            err_to <= 1'b1;
                        end
                    end else if (to_cnt != TO_LAST) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commu_seq.sv
// Scoreboard bench for commu_seq (NUM_PH=3, TIMEOUT=8, MAX_RETRY=2): stimulus pushes the
// expected output events with their cycle numbers; a negedge monitor pops and compares.
module tb_commu_seq;

    localparam int NUM_PH = 3;
    localparam int PH_W   = 2;
    localparam int RC_W   = 2;

    logic              clk_sys = 1'b0;
    logic              rst_n;
    logic [NUM_PH-1:0] fire;
    logic [NUM_PH-1:0] done;
    logic              pk_frm;
    logic              slot_rdy;
    logic [7:0]        cmd_retry;
    logic              busy;
    logic [PH_W-1:0]   ph_cur;
    logic [RC_W-1:0]   retry_cnt;
    logic              seq_ok;
    logic              err_to;

    commu_seq #(
        .NUM_PH(NUM_PH), .TO_W(16), .TIMEOUT(8), .MAX_RETRY(2), .RETRY_W(8)
    ) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .fire(fire), .done(done), .pk_frm(pk_frm),
        .slot_rdy(slot_rdy), .cmd_retry(cmd_retry), .busy(busy), .ph_cur(ph_cur),
        .retry_cnt(retry_cnt), .seq_ok(seq_ok), .err_to(err_to)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        logic [NUM_PH-1:0] fire;
        logic             ok;
        logic             er;
        logic [RC_W-1:0]  rc;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic push_ev(int c, logic [NUM_PH-1:0] f, logic ok, logic er, logic [RC_W-1:0] rc);
        ev_t e;
        e.cyc = c; e.fire = f; e.ok = ok; e.er = er; e.rc = rc;
        exp_q.push_back(e);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, want);
        end
    endtask

    task automatic at(int c);
        while (cyc < c) @(negedge clk_sys);
    endtask

    // monitor: every output event must match the head of the expectation queue
    always @(negedge clk_sys) begin
        if (fire != '0 || seq_ok || err_to) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event @cyc %0d: fire=%b seq_ok=%b err_to=%b", cyc, fire, seq_ok, err_to);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.fire !== fire || e.ok !== seq_ok || e.er !== err_to || e.rc !== retry_cnt) begin
                    bad++;
                    $display("FAIL event: got cyc=%0d fire=%b ok=%b er=%b rc=%0d want cyc=%0d fire=%b ok=%b er=%b rc=%0d",
                             cyc, fire, seq_ok, err_to, retry_cnt, e.cyc, e.fire, e.ok, e.er, e.rc);
                end
            end
        end
    end

    int n, c;

    initial begin
        rst_n = 1'b0; done = '0; pk_frm = 1'b0; slot_rdy = 1'b0; cmd_retry = '0;
        repeat (3) @(negedge clk_sys);
        chk("rst_fire", 32'(fire), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ph", 32'(ph_cur), 0);
        chk("rst_rc", 32'(retry_cnt), 0);
        chk("rst_ok_err", {30'd0, seq_ok, err_to}, 0);
        rst_n = 1'b1;
        at(cyc + 2);

        // 1: slot_rdy launch, each done 2 cycles after its fire
        n = cyc; c = n + 1;
        push_ev(c, 3'b001, 0, 0, 0);
        push_ev(c + 3, 3'b010, 0, 0, 0);
        push_ev(c + 6, 3'b100, 0, 0, 0);
        push_ev(c + 9, 3'b000, 1, 0, 0);
        slot_rdy = 1'b1;
        at(c);     slot_rdy = 1'b0;
        chk("t1_busy_fire", 32'(busy), 1);
        at(c + 2); done = 3'b001;
        at(c + 3); done = '0;
        chk("t1_ph1", 32'(ph_cur), 1);
        at(c + 5); done = 3'b010;
        at(c + 6); done = '0;
        at(c + 8); done = 3'b100;
        at(c + 9); done = '0;
        chk("t1_busy_done", 32'(busy), 1);
        at(c + 10);
        chk("t1_busy_idle", 32'(busy), 0);
        at(c + 12);

        // 2: pk_frm with slot_rdy parks in BUF; cmd 01 does nothing; cmd 03 launches
        n = cyc;
        pk_frm = 1'b1; slot_rdy = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            at(n + k);
            if (k == 5) begin pk_frm = 1'b0; slot_rdy = 1'b0; end
            chk("t2_buf_busy", 32'(busy), 0);
        end
        cmd_retry = 8'h01;
        at(n + 7); chk("t2_cmd01_busy", 32'(busy), 0);
        at(n + 8); chk("t2_cmd01_busy", 32'(busy), 0);
        cmd_retry = 8'h03;
        c = n + 9;
        // fastest sequence: done in the first WAIT cycle of every phase
        push_ev(c, 3'b001, 0, 0, 0);
        push_ev(c + 2, 3'b010, 0, 0, 0);
        push_ev(c + 4, 3'b100, 0, 0, 0);
        push_ev(c + 6, 3'b000, 1, 0, 0);
        at(c); cmd_retry = '0;
        for (int k = 0; k < 3; k++) begin
            at(c + 2 * k + 1); done = 3'(1 << k);
            at(c + 2 * k + 2); done = '0;
        end
        at(c + 9);

        // 3: done[1] never comes -> two restarts, then err_to
        n = cyc; c = n + 1;
        for (int r = 0; r < 3; r++) begin
            push_ev(c + 11 * r, 3'b001, 0, 0, 2'(r));
            push_ev(c + 11 * r + 2, 3'b010, 0, 0, 2'(r));
        end
        push_ev(c + 33, 3'b000, 0, 1, 2);
        slot_rdy = 1'b1;
        at(c); slot_rdy = 1'b0;
        for (int r = 0; r < 3; r++) begin
            at(c + 11 * r + 1); done = 3'b001;
            at(c + 11 * r + 2); done = '0;
        end
        at(c + 33);
        chk("t3_busy_err", 32'(busy), 1);
        at(c + 34);
        chk("t3_busy_idle", 32'(busy), 0);
        chk("t3_rc_hold", 32'(retry_cnt), 2);
        at(c + 36);

        // 4: done[1] on the timeout cycle of phase 1 -> fire[2], no retry
        n = cyc; c = n + 1;
        push_ev(c, 3'b001, 0, 0, 0);
        push_ev(c + 2, 3'b010, 0, 0, 0);
        push_ev(c + 11, 3'b100, 0, 0, 0);
        push_ev(c + 13, 3'b000, 1, 0, 0);
        slot_rdy = 1'b1;
        at(c);      slot_rdy = 1'b0;
        at(c + 1);  done = 3'b001;
        at(c + 2);  done = '0;
        at(c + 10); done = 3'b010;
        at(c + 11); done = '0;
        chk("t4_ph2", 32'(ph_cur), 2);
        chk("t4_rc", 32'(retry_cnt), 0);
        at(c + 12); done = 3'b100;
        at(c + 13); done = '0;
        at(c + 16);

        // 5: reset in WAIT of phase 1, later done[1] must not fire anything
        n = cyc; c = n + 1;
        push_ev(c, 3'b001, 0, 0, 0);
        push_ev(c + 2, 3'b010, 0, 0, 0);
        slot_rdy = 1'b1;
        at(c);     slot_rdy = 1'b0;
        at(c + 1); done = 3'b001;
        at(c + 2); done = '0;
        at(c + 4);
        chk("t5_pre_ph", 32'(ph_cur), 1);
        rst_n = 1'b0;
        at(c + 5); rst_n = 1'b1;
        chk("t5_fire", 32'(fire), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_ph", 32'(ph_cur), 0);
        chk("t5_ok_err", {30'd0, seq_ok, err_to}, 0);
        at(c + 6); done = 3'b010;
        at(c + 8); done = '0;
        chk("t5_busy_after_done", 32'(busy), 0);
        at(c + 10);

        // 6: done[2] held in phase 0 and done[0] during FIRE are ignored
        n = cyc; c = n + 1;
        push_ev(c, 3'b001, 0, 0, 0);
        push_ev(c + 5, 3'b010, 0, 0, 0);
        push_ev(c + 7, 3'b100, 0, 0, 0);
        push_ev(c + 9, 3'b000, 1, 0, 0);
        slot_rdy = 1'b1; done = 3'b100;
        at(c);     slot_rdy = 1'b0; done = 3'b101;
        at(c + 1); done = 3'b100;
        at(c + 3);
        chk("t6_still_ph0", 32'(ph_cur), 0);
        at(c + 4); done = 3'b101;
        at(c + 5); done = '0;
        at(c + 6); done = 3'b010;
        at(c + 7); done = '0;
        at(c + 8); done = 3'b100;
        at(c + 9); done = '0;
        at(c + 12);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
